// File: rtl/agp_core_target.sv
// AGP-style pipelined target: queues master read/write requests issued during a grant,
// then services them in order against a simple req/ack backend with registered outputs.
module agp_core_target #(
   parameter int QDEPTH      = 8,
   parameter int GNT_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req,
   output logic                    gnt,
   output logic [2:0]              st,
   input  logic                    pipe,
   inout  wire  [31:0]             ad,
   input  logic [3:0]              c_be,
   input  logic                    irdy,
   output logic                    trdy,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [28:0]             mem_addr,
   output logic [63:0]             mem_wdata,
   input  logic [63:0]             mem_rdata,
   input  logic                    mem_ack,
   output logic [$clog2(QDEPTH):0] q_count,
   output logic                    overflow
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(GNT_TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_MEM_RD, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI, S_MEM_WR
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          seen_q, seen_d;
   logic          overflow_q, overflow_d;
   logic [63:0]   rdata_q, rdata_d;
   logic [31:0]   wdata_lo_q, wdata_lo_d;
   logic          gnt_q, gnt_d, trdy_q, trdy_d, ad_oe_q, ad_oe_d;
   logic [2:0]    st_q, st_d;
   logic [31:0]   ad_out_q, ad_out_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [28:0]   mem_addr_q, mem_addr_d;
   logic [63:0]   mem_wdata_q, mem_wdata_d;

   // entry = {is_write, qword address}
   logic [29:0]   q_mem [QDEPTH];
   logic [29:0]   head;
   logic          enq, pop, full, empty, cmd_ok;

   assign head   = q_mem[rd_ptr_q];
   assign full   = (count_q == CW'(QDEPTH));
   assign empty  = (count_q == '0);
   assign cmd_ok = (c_be == 4'b0000) || (c_be == 4'b0100);

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      seen_d      = seen_q;
      overflow_d  = overflow_q;
      rdata_d     = rdata_q;
      wdata_lo_d  = wdata_lo_q;
      mem_wdata_d = mem_wdata_q;
      enq         = 1'b0;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = head[29] ? S_WR_LO : S_MEM_RD;
            end else if (!req && !full) begin
               state_d = S_GRANT;
               tmo_d   = '0;
               seen_d  = 1'b0;
            end
         end
         S_GRANT: begin
            if (!pipe) begin
               seen_d = 1'b1;
               if (cmd_ok) begin
                  if (full) overflow_d = 1'b1;
                  else      enq = 1'b1;
               end
            end
            // timeout only runs until the master has issued its first strobe
            if (full || (pipe && seen_q) ||
                (pipe && !seen_q && tmo_q == TW'(GNT_TIMEOUT - 1))) begin
               state_d = S_IDLE;
            end else if (pipe && !seen_q) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_MEM_RD: begin
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = S_RD_LO;
            end
         end
         S_RD_LO: state_d = S_RD_HI;
         S_RD_HI: begin
            pop     = 1'b1;
            state_d = S_IDLE;
         end
         S_WR_LO: begin
            if (!irdy) begin
               wdata_lo_d = ad;
               state_d    = S_WR_HI;
            end
         end
         S_WR_HI: begin
            mem_wdata_d = {ad, wdata_lo_q};
            state_d     = S_MEM_WR;
         end
         S_MEM_WR: begin
            if (mem_ack) begin
               pop     = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(enq) - CW'(pop);

      // outputs are decoded from the next state so they line up with the state register
      gnt_d      = !(state_d inside {S_GRANT, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI});
      st_d       = (state_d inside {S_RD_LO, S_RD_HI}) ? 3'b000 :
                   (state_d inside {S_WR_LO, S_WR_HI}) ? 3'b010 : 3'b111;
      trdy_d     = !(state_d inside {S_RD_LO, S_RD_HI});
      ad_oe_d    = (state_d inside {S_RD_LO, S_RD_HI});
      ad_out_d   = (state_d == S_RD_LO) ? rdata_d[31:0] :
                   (state_d == S_RD_HI) ? rdata_d[63:32] : 32'h0;
      mem_req_d  = (state_d inside {S_MEM_RD, S_MEM_WR});
      mem_we_d   = (state_d == S_MEM_WR);
      mem_addr_d = mem_req_d ? head[28:0] : mem_addr_q;
   end

   always_ff @(posedge clk) begin
      if (enq) q_mem[wr_ptr_q] <= {c_be == 4'b0100, ad[31:3]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tmo_q       <= '0;
         seen_q      <= 1'b0;
         overflow_q  <= 1'b0;
         rdata_q     <= '0;
         wdata_lo_q  <= '0;
         gnt_q       <= 1'b1;
         st_q        <= 3'b111;
         trdy_q      <= 1'b1;
         ad_oe_q     <= 1'b0;
         ad_out_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tmo_q       <= tmo_d;
         seen_q      <= seen_d;
         overflow_q  <= overflow_d;
         rdata_q     <= rdata_d;
         wdata_lo_q  <= wdata_lo_d;
         gnt_q       <= gnt_d;
         st_q        <= st_d;
         trdy_q      <= trdy_d;
         ad_oe_q     <= ad_oe_d;
         ad_out_q    <= ad_out_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign ad        = ad_oe_q ? ad_out_q : 32'hzzzz_zzzz;
   assign gnt       = gnt_q;
   assign st        = st_q;
   assign trdy      = trdy_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign q_count   = count_q;
   assign overflow  = overflow_q;
endmodule
